// File: rtl/log_capture_pkg.sv
// log_capture_pkg: shared types and helpers for the multi-channel log capture memory.
package log_capture_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Capture modes, latched on the run edge.
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CIRC    = 1'b1;

  // Ceiling log2, used to derive address and channel-select widths.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage : log_capture_pkg

// File: rtl/log_bram_sdp.sv
// log_bram_sdp: simple dual-port block RAM, one write port and one registered
// read port, RAM_WIDTH x RAM_DEPTH. One instance per capture channel.
module log_bram_sdp #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [RAM_WIDTH-1:0] rd_data
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // Write port.
  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // read output register below is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : log_bram_sdp

// File: rtl/log_capture_mem.sv
// log_capture_mem: N_CH-channel sample capture into per-channel block RAM with
// decimation, one-shot fill or circular (stop-triggered) capture, and a
// 2-cycle file-register read port addressed relative to the oldest sample.
// Optional feature macro: LOG_CAPTURE_POSTTRIG_EN -- in circular mode, i_stop
// arms a post-trigger counter and capture runs POST_TRIG more stored samples.
module log_capture_mem
  import log_capture_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  parameter int N_CH      = 2,
  parameter int NB_DECIM  = 8,
`ifdef LOG_CAPTURE_POSTTRIG_EN
  parameter int POST_TRIG = RAM_DEPTH / 2,
`endif
  localparam int ADDR_W   = clogb2(RAM_DEPTH),
  localparam int CH_W     = (N_CH > 1) ? clogb2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_run_log,
  input  logic                      i_mode,
  input  logic                      i_stop,
  input  logic [NB_DECIM-1:0]       i_decim,
  input  logic [N_CH*RAM_WIDTH-1:0] i_data,
  input  logic                      i_read_log,
  input  logic [CH_W-1:0]           i_ch_sel,
  input  logic [ADDR_W-1:0]         i_addr,
  output logic [RAM_WIDTH-1:0]      o_data,
  output logic                      o_data_valid,
  output logic                      o_mem_full,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_wr_ptr
);

  // ---------------------------------------------------------------------------
  // Capture control state
  // ---------------------------------------------------------------------------
  state_t              state;
  logic                run_q;
  logic                run_edge;
  logic                mode_q;
  logic [NB_DECIM-1:0] decim_q;
  logic [NB_DECIM-1:0] dcnt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic                wrapped;
  logic                mem_full;
  logic                busy;
  logic                we;
  logic                cap_end;
`ifdef LOG_CAPTURE_POSTTRIG_EN
  logic                armed;
  logic [31:0]         pt_cnt;
`endif

  // A fresh run edge takes priority over any write in the same cycle, so a
  // restart never leaves a stray sample at the old pointer.
  assign run_edge = i_run_log & ~run_q;
  assign we       = (state == CAPTURE) && (dcnt == '0) && !run_edge;

  // Run-edge detector register.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= i_run_log;
    end
  end

  // Decide whether this cycle ends the capture.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    cap_end = 1'b0;
    if (state == CAPTURE && !run_edge) begin
      if (mode_q == MODE_ONESHOT) begin
        cap_end = we && (wr_ptr == '1);
      end else begin
`ifdef LOG_CAPTURE_POSTTRIG_EN
        if (armed) begin
          cap_end = we && (pt_cnt == 32'(POST_TRIG - 1));
        end else if (i_stop && (POST_TRIG == 0)) begin
          cap_end = 1'b1;
        end
`else
        cap_end = i_stop;
`endif
      end
    end
  end

  // Capture FSM: run edge, decimation, write pointer, wrap and status flags.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= MODE_ONESHOT;
      decim_q  <= '0;
      dcnt     <= '0;
      wr_ptr   <= '0;
      wrapped  <= 1'b0;
      mem_full <= 1'b0;
      busy     <= 1'b0;
`ifdef LOG_CAPTURE_POSTTRIG_EN
      armed    <= 1'b0;
      pt_cnt   <= '0;
`endif
    end else if (run_edge) begin
      state    <= CAPTURE;
      mode_q   <= i_mode;
      decim_q  <= i_decim;
      dcnt     <= '0;
      wr_ptr   <= '0;
      wrapped  <= 1'b0;
      mem_full <= 1'b0;
      busy     <= 1'b1;
`ifdef LOG_CAPTURE_POSTTRIG_EN
      armed    <= 1'b0;
      pt_cnt   <= '0;
`endif
    end else begin
      case (state)
        CAPTURE: begin
          dcnt <= (dcnt == decim_q) ? '0 : dcnt + 1'b1;
          if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == '1 && mode_q == MODE_CIRC) begin
              wrapped <= 1'b1;
            end
          end
`ifdef LOG_CAPTURE_POSTTRIG_EN
          if (mode_q == MODE_CIRC) begin
            if (armed) begin
              if (we) begin
                pt_cnt <= pt_cnt + 32'd1;
              end
            end else if (i_stop) begin
              armed  <= 1'b1;
              pt_cnt <= '0;
            end
          end
`endif
          if (cap_end) begin
            state    <= DONE;
            mem_full <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: logical address -> physical address, 2-cycle latency
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]    base;
  logic [ADDR_W-1:0]    phys;
  logic                 rd_accept;
  logic                 rd_v1;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [CH_W-1:0]      ch_q;
  logic [CH_W-1:0]      ch_q2;
  logic                 data_valid;
  logic [RAM_WIDTH-1:0] rd_data [N_CH];

  // Once wrapped, the oldest sample sits at the write pointer; address wraps
  // naturally because RAM_DEPTH is a power of two.
  assign base      = wrapped ? wr_ptr : '0;
  assign phys      = base + i_addr;
  assign rd_accept = i_read_log && (state != CAPTURE);

  // Read stage 1: register physical address and channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v1     <= 1'b0;
      rd_addr_q <= '0;
      ch_q      <= '0;
    end else begin
      rd_v1 <= rd_accept;
      if (rd_accept) begin
        rd_addr_q <= phys;
        ch_q      <= i_ch_sel;
      end
    end
  end

  // Read stage 2: BRAM output registers load; keep the channel that goes with them.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid <= 1'b0;
      ch_q2      <= '0;
    end else begin
      data_valid <= rd_v1;
      if (rd_v1) begin
        ch_q2 <= ch_q;
      end
    end
  end

  // Per-channel block RAMs sharing write pointer and read address.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    log_bram_sdp #(
      .RAM_WIDTH (RAM_WIDTH),
      .RAM_DEPTH (RAM_DEPTH),
      .ADDR_W    (ADDR_W)
    ) u_bram (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .wr_addr (wr_ptr),
      .wr_data (i_data[k*RAM_WIDTH +: RAM_WIDTH]),
      .rd_en   (rd_v1),
      .rd_addr (rd_addr_q),
      .rd_data (rd_data[k])
    );
  end

  // Output mux over channels on the registered select; unused codes read 0.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q2 == CH_W'(k)) begin
        o_data = rd_data[k];
      end
    end
  end

  assign o_data_valid = data_valid;
  assign o_mem_full   = mem_full;
  assign o_busy       = busy;
  assign o_wr_ptr     = wr_ptr;

endmodule : log_capture_mem

// File: tb/tb_log_capture_mem.sv
// tb_log_capture_mem: directed bench for log_capture_mem with a queue-based
// reference model checked every cycle, plus hand-computed literal checks.
// Define LOG_CAPTURE_POSTTRIG_EN to exercise the post-trigger build.
module tb_log_capture_mem;

  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int NCH   = 2;
  localparam int AW    = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_run_log;
  logic           i_mode;
  logic           i_stop;
  logic [7:0]     i_decim;
  logic [NCH*W-1:0] i_data;
  logic           i_read_log;
  logic [0:0]     i_ch_sel;
  logic [AW-1:0]  i_addr;
  logic [W-1:0]   o_data;
  logic           o_data_valid;
  logic           o_mem_full;
  logic           o_busy;
  logic [AW-1:0]  o_wr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  log_capture_mem #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (DEPTH),
    .N_CH      (NCH),
`ifdef LOG_CAPTURE_POSTTRIG_EN
    .POST_TRIG (512),
`endif
    .NB_DECIM  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_run_log    (i_run_log),
    .i_mode       (i_mode),
    .i_stop       (i_stop),
    .i_decim      (i_decim),
    .i_data       (i_data),
    .i_read_log   (i_read_log),
    .i_ch_sel     (i_ch_sel),
    .i_addr       (i_addr),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_mem_full   (o_mem_full),
    .o_busy       (o_busy),
    .o_wr_ptr     (o_wr_ptr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: stored samples kept as an ordered history per channel.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_CAP, M_DONE} mstate_t;
  mstate_t     m_st;
  logic [31:0] h0[$];
  logic [31:0] h1[$];
  logic        m_busy, m_full, m_mode, m_armed, m_run_prev;
  int          m_decim, m_cyc, m_post;
  logic        m_v1, m_v2, m_rd_known, m_dat_known;
  logic [31:0] m_rd_val, m_dat;
  bit          model_ok = 0;

  // Logical address 0 is the oldest of the most recent DEPTH samples.
  task automatic lookup(input logic ch, input int addr, output logic [31:0] val, output logic known);
    int n, start, idx;
    n     = h0.size();
    start = (n > DEPTH) ? n - DEPTH : 0;
    idx   = start + addr;
    known = (idx < n);
    val   = '0;
    if (known) val = ch ? h1[idx] : h0[idx];
  endtask

  always @(posedge clk) begin
    logic run_rise, wr, fin;
    if (reset) begin
      m_st = M_IDLE; m_busy = 0; m_full = 0; m_armed = 0; m_run_prev = 0;
      h0.delete(); h1.delete();
      m_v1 = 0; m_v2 = 0; m_dat = '0; m_dat_known = 1; m_rd_known = 0;
      model_ok = 1;
    end else begin
      m_v2 = m_v1;
      if (m_v1) begin m_dat = m_rd_val; m_dat_known = m_rd_known; end
      m_v1 = i_read_log && (m_st != M_CAP);
      if (m_v1) lookup(i_ch_sel[0], int'(i_addr), m_rd_val, m_rd_known);
      run_rise   = i_run_log && !m_run_prev;
      m_run_prev = i_run_log;
      if (run_rise) begin
        m_st = M_CAP; m_mode = i_mode; m_decim = int'(i_decim); m_cyc = 1;
        m_busy = 1; m_full = 0; m_armed = 0;
        h0.delete(); h1.delete();
      end else if (m_st == M_CAP) begin
        wr  = ((m_cyc - 1) % (m_decim + 1)) == 0;
        fin = 0;
        m_cyc++;
        if (wr) begin h0.push_back(i_data[W-1:0]); h1.push_back(i_data[2*W-1:W]); end
        if (!m_mode) fin = wr && (h0.size() == DEPTH);
        else begin
`ifdef LOG_CAPTURE_POSTTRIG_EN
          if (m_armed) begin
            if (wr) m_post++;
            fin = (m_post == 512);
          end else if (i_stop) begin
            m_armed = 1; m_post = 0;
          end
`else
          fin = i_stop;
`endif
        end
        if (fin) begin m_st = M_DONE; m_busy = 0; m_full = 1; end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("busy", 32'(o_busy), 32'(m_busy));
      check("mem_full", 32'(o_mem_full), 32'(m_full));
      check("wr_ptr", 32'(o_wr_ptr), 32'(h0.size() % DEPTH));
      check("data_valid", 32'(o_data_valid), 32'(m_v2));
      if (m_dat_known) check("data", o_data, m_dat);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: cycle index since last run edge drives the ramp data.
  // ---------------------------------------------------------------------------
  int cyc_idx = 0;

  task automatic step();
    @(posedge clk); #1;
    cyc_idx++;
    i_data = {~32'(cyc_idx), 32'(cyc_idx)};
  endtask

  task automatic start_run(input logic mode, input logic [7:0] decim);
    i_mode = mode; i_decim = decim; i_run_log = 1'b1;
    cyc_idx = 0;
    i_data = {~32'd0, 32'd0};
    step();
    i_run_log = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (cyc_idx < c) step();
  endtask

  task automatic wait_full(input int limit);
    int guard = 0;
    while (!o_mem_full && guard < limit) begin step(); guard++; end
    if (!o_mem_full) check("full_timeout", 32'(o_mem_full), 32'd1);
  endtask

  task automatic do_read(input string name, input logic ch, input int addr, input logic [31:0] exp);
    i_read_log = 1'b1; i_ch_sel = ch; i_addr = AW'(addr);
    step();
    i_read_log = 1'b0;
    check({name, "_valid_early"}, 32'(o_data_valid), 32'd0);
    step();
    check({name, "_valid"}, 32'(o_data_valid), 32'd1);
    check(name, o_data, exp);
  endtask

  initial begin
    reset = 1'b1; i_run_log = 0; i_mode = 0; i_stop = 0; i_decim = '0;
    i_data = '0; i_read_log = 0; i_ch_sel = '0; i_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_full", 32'(o_mem_full), 32'd0);
    check("rst_wr_ptr", 32'(o_wr_ptr), 32'd0);
    check("rst_valid", 32'(o_data_valid), 32'd0);
    check("rst_data", o_data, 32'd0);
    step();

    // 1: one-shot, no decimation.
    start_run(1'b0, 8'd0);
    check("t1_busy", 32'(o_busy), 32'd1);
    wait_full(1100);
    check("t1_full_cycle", 32'(cyc_idx), 32'd1025);
    check("t1_busy_done", 32'(o_busy), 32'd0);
    do_read("t1_ch0_a5", 1'b0, 5, 32'd6);
    do_read("t1_ch1_a5", 1'b1, 5, ~32'd6);
    do_read("t1_ch0_a0", 1'b0, 0, 32'd1);
    do_read("t1_ch0_a1023", 1'b0, 1023, 32'd1024);

    // 2: one-shot, decimation by 4.
    start_run(1'b0, 8'd3);
    wait_full(4200);
    check("t2_full_cycle", 32'(cyc_idx), 32'd4094);
    do_read("t2_a0", 1'b0, 0, 32'd1);
    do_read("t2_a1", 1'b0, 1, 32'd5);
    do_read("t2_a1023", 1'b0, 1023, 32'd4093);

`ifndef LOG_CAPTURE_POSTTRIG_EN
    // 3: circular, stop coincident with write 1500.
    start_run(1'b1, 8'd0);
    run_until(1500);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("t3_full", 32'(o_mem_full), 32'd1);
    check("t3_wr_ptr", 32'(o_wr_ptr), 32'd476);
    do_read("t3_a0", 1'b0, 0, 32'd477);
    do_read("t3_a1023", 1'b0, 1023, 32'd1500);

    // 4: circular, stop before wrap.
    start_run(1'b1, 8'd0);
    run_until(100);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("t4_full", 32'(o_mem_full), 32'd1);
    check("t4_busy", 32'(o_busy), 32'd0);
    do_read("t4_a0", 1'b0, 0, 32'd1);
    do_read("t4_a99", 1'b0, 99, 32'd100);
`endif

    // 5: read ignored during capture, then reset mid-capture.
    start_run(1'b1, 8'd0);
    run_until(50);
    i_read_log = 1'b1; i_ch_sel = '0; i_addr = '0;
    step();
    i_read_log = 1'b0;
    check("t5_no_valid1", 32'(o_data_valid), 32'd0);
    step();
    check("t5_no_valid2", 32'(o_data_valid), 32'd0);
    run_until(300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy", 32'(o_busy), 32'd0);
    check("t5_full", 32'(o_mem_full), 32'd0);
    check("t5_wr_ptr", 32'(o_wr_ptr), 32'd0);
    step();

`ifdef LOG_CAPTURE_POSTTRIG_EN
    // 6: post-trigger, stop at write 2000, repeat stop ignored.
    start_run(1'b1, 8'd0);
    run_until(2000);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    run_until(2100);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("t6_busy_armed", 32'(o_busy), 32'd1);
    wait_full(600);
    check("t6_full_cycle", 32'(cyc_idx), 32'd2513);
    do_read("t6_a511", 1'b0, 511, 32'd2000);
    do_read("t6_a1023", 1'b0, 1023, 32'd2512);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_log_capture_mem
